sudoku_rand_picker: RTL and testbench
=====================================

# sudoku_rand_picker

Downstream consumer of the LFSR random source. Requests 4-bit random nibbles, rejection-samples them into a legal Sudoku triple (row 0–8, column 0–8, digit 1–9) and presents the triple on a valid/ready handshake to the puzzle-setup FSM. Bounded retries per field guarantee forward progress: when the retry budget is exhausted, a folded value is used.

## Interface
- MAX_TRIES, 8, rejected draws allowed per field before the fold fallback (range 1–255)
- in_clka  in  1  sole clock, rising edge
- in_rst_n  in  1  asynchronous, active-low reset
- en  in  1  allow new picks; sampled in IDLE only
- gen_rand_flag  out  1  draw request to the RNG; high in ROW/COL/DIG
- rand_vld  in  1  rand_nib holds a fresh draw this cycle
- rand_nib  in  4  random nibble from the RNG
- pick_valid  out  1  triple available
- pick_ready  in  1  consumer accepts the triple
- pick_row  out  4  0–8
- pick_col  out  4  0–8
- pick_digit  out  4  1–9
- pick_folded  out  1  at least one field of this triple used the fold fallback
- rej_count  out  16  total rejected draws (only with PICKER_STATS_EN)

## Operation
- States: IDLE, ROW, COL, DIG, OUT.
- IDLE -> ROW when en = 1.
- A draw is consumed on any edge where gen_rand_flag & rand_vld.
- Acceptance rules:
  - ROW and COL accept nib ≤ 8.
  - DIG accepts 1 ≤ nib ≤ 9.
- On accept: store the field, clear the try counter, advance ROW -> COL -> DIG -> OUT.
- On reject: increment the try counter and stay in the same state.
- Fold on the MAX_TRIES-th consecutive reject: accept the folded value instead and set the sticky fold bit.
  - ROW/COL fold: nib − 9. Rejected nibs are 9–15, giving 0–6.
  - DIG fold: nib = 0 -> 1; nib 10–15 -> nib − 9, giving 1–6.
- OUT: pick_valid = 1. On pick_valid & pick_ready, go to ROW if en = 1, else IDLE. Clear the fold bit on exit.
- While pick_valid is high, all pick_* outputs stay stable regardless of rand_nib and en.
- The try counter is 8 bits wide and never wraps, because the fold fires first.
- rand_vld high outside ROW/COL/DIG is ignored.

## Timing
- Reset values:
  - state IDLE
  - gen_rand_flag 0, pick_valid 0
  - pick_row 0, pick_col 0, pick_digit 1
  - pick_folded 0, try counter 0, rej_count 0
- Reset mid-pick discards partial fields and returns to IDLE asynchronously.
- gen_rand_flag and pick_valid are registered, decoded from the state register.
- Best-case latency, en = 1 with rand_vld tied high: gen_rand_flag rises 1 cycle after en is sampled; pick_valid rises 3 cycles after that (one draw per field).
- Back-to-back picks: the cycle after the OUT handshake is ROW with gen_rand_flag = 1. No idle bubble beyond the handshake cycle.
- Worst case per field: MAX_TRIES draws.

## Configuration
- PICKER_STATS_EN defined: rej_count increments on every rejected draw, including the one that triggers a fold. It saturates at 16'hFFFF and is cleared only by reset.
- Not defined: rej_count port and counter are absent; no stats logic.

## Structure
- Shared package `sudoku_pkg`:
  - picker state enum
  - constants GRID_MAX = 8, DIGIT_MIN = 1, DIGIT_MAX = 9, FOLD_OFFSET = 9
- One natural sub-module: `nib_classify`. Combinational; given field type and nib, returns accept and folded_value. It is shared by all three draw states.

## Test plan
- Reset, then en = 1, rand_nib sequence 3, 7, 5 with rand_vld = 1 -> pick_valid after 4 cycles with row 3, col 7, digit 5, pick_folded 0.
- ROW draws 12, 9, 4 -> row 4. Same for DIG: draw 0 is rejected, draw 10 is rejected, draw 9 is accepted -> digit 9. rej_count = 4 (stats build).
- MAX_TRIES = 2, ROW draws 15, 13 -> row 4 (13 − 9), pick_folded = 1. DIG draws 0, 0 -> digit 1.
- Hold pick_ready = 0 for 10 cycles while rand_nib toggles -> pick_* outputs unchanged and gen_rand_flag = 0. Then ready = 1 with en = 1 -> next cycle is ROW.
- Assert in_rst_n low in the COL state -> IDLE immediately and all outputs at their reset values. The next pick ignores the stale row.
- Drop en during OUT, then handshake -> IDLE, gen_rand_flag stays 0 and rand_vld pulses are ignored.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku random picker.
//   picker_state_e : picker FSM states
//   field_e        : which kind of field a draw is for (grid index or digit)
//   GRID_MAX, DIGIT_MIN, DIGIT_MAX, FOLD_OFFSET : legal-range and fold constants
package sudoku_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW,
    ST_COL,
    ST_DIG,
    ST_OUT
  } picker_state_e;

  typedef enum logic {
    FIELD_GRID,
    FIELD_DIGIT
  } field_e;

  localparam logic [3:0] GRID_MAX    = 4'd8;
  localparam logic [3:0] DIGIT_MIN   = 4'd1;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] FOLD_OFFSET = 4'd9;

endpackage

// File: rtl/sudoku_rand_picker_if.sv
// Handshake bundle between the picker, its RNG and the puzzle-setup consumer.
//   master : the picker (drives draw request and the pick triple)
//   slave  : the environment (drives en, RNG draw, consumer ready)
// Signals: en, gen_rand_flag, rand_vld, rand_nib[3:0], pick_valid, pick_ready,
//          pick_row[3:0], pick_col[3:0], pick_digit[3:0], pick_folded.
interface sudoku_rand_picker_if;

  logic       en;
  logic       gen_rand_flag;
  logic       rand_vld;
  logic [3:0] rand_nib;
  logic       pick_valid;
  logic       pick_ready;
  logic [3:0] pick_row;
  logic [3:0] pick_col;
  logic [3:0] pick_digit;
  logic       pick_folded;

  modport master (
    input  en, rand_vld, rand_nib, pick_ready,
    output gen_rand_flag, pick_valid, pick_row, pick_col, pick_digit, pick_folded
  );

  modport slave (
    output en, rand_vld, rand_nib, pick_ready,
    input  gen_rand_flag, pick_valid, pick_row, pick_col, pick_digit, pick_folded
  );

endinterface

// File: rtl/sudoku_rand_picker_nib_classify.sv
// nib_classify: combinational legality check for one random nibble.
//   field_i        : FIELD_GRID (row/col, legal 0..8) or FIELD_DIGIT (legal 1..9)
//   nib_i          : drawn nibble
//   accept_o       : nibble is legal as-is for this field
//   folded_value_o : fallback value used when the retry budget runs out;
//                    only meaningful when accept_o is 0
module nib_classify
  import sudoku_pkg::*;
(
  input  field_e     field_i,
  input  logic [3:0] nib_i,
  output logic       accept_o,
  output logic [3:0] folded_value_o
);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    accept_o       = 1'b0;
    folded_value_o = nib_i - FOLD_OFFSET;
    if (field_i == FIELD_GRID) begin
      // Rejected grid nibs are 9..15, so subtracting 9 lands in 0..6.
      accept_o = (nib_i <= GRID_MAX);
    end else begin
      accept_o = (nib_i >= DIGIT_MIN) && (nib_i <= DIGIT_MAX);
      // Zero is the only reject below the range; map it to the smallest digit.
      if (nib_i == 4'd0) folded_value_o = DIGIT_MIN;
    end
  end

endmodule

// File: rtl/sudoku_rand_picker.sv
// sudoku_rand_picker: rejection-samples RNG nibbles into a legal Sudoku
// triple (row 0..8, col 0..8, digit 1..9) and offers it on valid/ready.
// After MAX_TRIES consecutive rejects for one field the rejected nibble is
// folded into range and pick_folded is raised for that triple.
//   in_clka, in_rst_n : clock (rising edge), async active-low reset
//   bus (master)      : en, RNG draw (gen_rand_flag/rand_vld/rand_nib),
//                       pick triple handshake
//   rej_count         : saturating count of rejected draws, present only
//                       when PICKER_STATS_EN is defined
module sudoku_rand_picker
  import sudoku_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 8  // 1..255
) (
  input  logic                 in_clka,
  input  logic                 in_rst_n,
  sudoku_rand_picker_if.master bus
`ifdef PICKER_STATS_EN
  ,
  output logic [15:0]          rej_count
`endif
);

  picker_state_e state_q, state_d;
  logic          gen_q, gen_d;
  logic          valid_q, valid_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    dig_q, dig_d;
  logic          folded_q, folded_d;
  logic [7:0]    tries_q, tries_d;

  field_e     field;
  logic       accept;
  logic [3:0] folded_value;
  logic       draw;
  logic       last_try;
  logic       take;
  logic [3:0] take_value;

  assign field = (state_q == ST_DIG) ? FIELD_DIGIT : FIELD_GRID;

  nib_classify u_classify (
    .field_i        (field),
    .nib_i          (bus.rand_nib),
    .accept_o       (accept),
    .folded_value_o (folded_value)
  );

  // gen_q is high exactly in the draw states, so it doubles as the draw qualifier.
  assign draw       = gen_q & bus.rand_vld;
  assign last_try   = (tries_q == 8'(MAX_TRIES - 1));
  assign take       = draw & (accept | last_try);
  assign take_value = accept ? bus.rand_nib : folded_value;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    dig_d    = dig_q;
    folded_d = folded_q;
    tries_d  = tries_q;

    unique case (state_q)
      ST_IDLE: if (bus.en) state_d = ST_ROW;
      ST_ROW, ST_COL, ST_DIG: begin
        if (take) begin
          tries_d = 8'd0;
          if (!accept) folded_d = 1'b1;
          case (state_q)
            ST_ROW:  begin row_d = take_value; state_d = ST_COL; end
            ST_COL:  begin col_d = take_value; state_d = ST_DIG; end
            default: begin dig_d = take_value; state_d = ST_OUT; end
          endcase
        end else if (draw) begin
          tries_d = tries_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (valid_q && bus.pick_ready) begin
          folded_d = 1'b0;
          state_d  = bus.en ? ST_ROW : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output flags are decoded from the next state so they come straight off flops.
    gen_d   = (state_d == ST_ROW) || (state_d == ST_COL) || (state_d == ST_DIG);
    valid_d = (state_d == ST_OUT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= ST_IDLE;
      gen_q    <= 1'b0;
      valid_q  <= 1'b0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      dig_q    <= DIGIT_MIN;
      folded_q <= 1'b0;
      tries_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      valid_q  <= valid_d;
      row_q    <= row_d;
      col_q    <= col_d;
      dig_q    <= dig_d;
      folded_q <= folded_d;
      tries_q  <= tries_d;
    end
  end

  assign bus.gen_rand_flag = gen_q;
  assign bus.pick_valid    = valid_q;
  assign bus.pick_row      = row_q;
  assign bus.pick_col      = col_q;
  assign bus.pick_digit    = dig_q;
  assign bus.pick_folded   = folded_q;

`ifdef PICKER_STATS_EN
  logic [15:0] rej_q;

  // Counts every reject, including the one that triggers a fold.
  always_ff @(posedge in_clka or negedge in_rst_n) begin
    if (!in_rst_n) begin
      rej_q <= 16'd0;
    end else if (draw && !accept && (rej_q != 16'hFFFF)) begin
      rej_q <= rej_q + 16'd1;
    end
  end

  assign rej_count = rej_q;
`endif

endmodule

// File: tb/tb_sudoku_rand_picker.sv
// Scoreboard bench for sudoku_rand_picker (MAX_TRIES = 8). Expected triples
// are queued when a pick is issued; a negedge monitor pops and compares on
// every pick_valid & pick_ready. Stats checks apply when PICKER_STATS_EN is set.
module tb_sudoku_rand_picker;
  import sudoku_pkg::*;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
    logic [3:0] d;
    logic       f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   first_valid_cyc = 0;
  bit   valid_prev = 1'b0;
  exp_t sb[$];
  logic [3:0] nib_q[$];
`ifdef PICKER_STATS_EN
  logic [15:0] rej_count;
`endif

  sudoku_rand_picker_if bus ();

  sudoku_rand_picker #(.MAX_TRIES(8)) dut (
    .in_clka  (clk),
    .in_rst_n (rst_n),
    .bus      (bus)
`ifdef PICKER_STATS_EN
    ,
    .rej_count(rej_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present queued nibbles one per cycle while the DUT requests draws.
  task automatic feed();
    while (nib_q.size() > 0) begin
      int w = 0;
      while (!bus.gen_rand_flag && w < 50) begin
        tick();
        w++;
      end
      if (!bus.gen_rand_flag) begin
        check("gen_timeout", 32'd0, 32'd1);
        nib_q.delete();
        bus.rand_vld = 1'b0;
        return;
      end
      bus.rand_nib = nib_q.pop_front();
      bus.rand_vld = 1'b1;
      tick();
    end
    bus.rand_vld = 1'b0;
  endtask

  task automatic pick(input logic [3:0] r, input logic [3:0] c, input logic [3:0] d, input logic f);
    sb.push_back('{r: r, c: c, d: d, f: f});
    feed();
    if (bus.pick_ready) tick();  // let the handshake edge pass
  endtask

  // Monitor: compare each accepted triple against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pick_valid && !valid_prev) first_valid_cyc = cyc;
      valid_prev = bus.pick_valid;
      if (bus.pick_valid && bus.pick_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pick", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pick_row",    32'(bus.pick_row),    32'(e.r));
          check("pick_col",    32'(bus.pick_col),    32'(e.c));
          check("pick_digit",  32'(bus.pick_digit),  32'(e.d));
          check("pick_folded", 32'(bus.pick_folded), 32'(e.f));
        end
      end
    end else begin
      valid_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n          = 1'b1;
    bus.en         = 1'b0;
    bus.rand_vld   = 1'b0;
    bus.rand_nib   = 4'd0;
    bus.pick_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    check("reset_gen",    32'(bus.gen_rand_flag), 32'd0);
    check("reset_valid",  32'(bus.pick_valid),    32'd0);
    check("reset_row",    32'(bus.pick_row),      32'd0);
    check("reset_col",    32'(bus.pick_col),      32'd0);
    check("reset_digit",  32'(bus.pick_digit),    32'd1);
    check("reset_folded", 32'(bus.pick_folded),   32'd0);
`ifdef PICKER_STATS_EN
    check("reset_rej", 32'(rej_count), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Basic pick and best-case latency.
    bus.en = 1'b1;
    c0 = cyc;
    nib_q = '{4'd3, 4'd7, 4'd5};
    pick(4'd3, 4'd7, 4'd5, 1'b0);
    check("latency_cycles", 32'(first_valid_cyc - c0), 32'd4);
    check("back_to_back_gen", 32'(bus.gen_rand_flag), 32'd1);

    // Rejects below the fold threshold.
    nib_q = '{4'd12, 4'd9, 4'd4, 4'd0, 4'd0, 4'd10, 4'd9};
    pick(4'd4, 4'd0, 4'd9, 1'b0);

    // Seven rejects then a legal draw: no fold.
    nib_q = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd2, 4'd8, 4'd9};
    pick(4'd2, 4'd8, 4'd9, 1'b0);

    // Eighth consecutive reject folds: row 14-9=5, digit 0 -> 1.
    nib_q = '{4'd15, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd9, 4'd14, 4'd8,
              4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    pick(4'd5, 4'd8, 4'd1, 1'b1);
`ifdef PICKER_STATS_EN
    check("rej_count_total", 32'(rej_count), 32'd27);
`endif

    // Hold ready low: outputs stay frozen, no draw request.
    bus.pick_ready = 1'b0;
    nib_q = '{4'd1, 4'd2, 4'd3};
    pick(4'd1, 4'd2, 4'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.rand_nib = 4'(i + 10);
      bus.rand_vld = 1'b1;
      bus.en       = i[0];
      tick();
      check("hold_outputs",
            32'({bus.pick_valid, bus.gen_rand_flag, bus.pick_row, bus.pick_col,
                 bus.pick_digit, bus.pick_folded}),
            32'({1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0}));
    end
    bus.rand_vld   = 1'b0;
    bus.en         = 1'b1;
    bus.pick_ready = 1'b1;
    tick();
    check("row_after_hold", 32'(bus.gen_rand_flag), 32'd1);
    nib_q = '{4'd4, 4'd5, 4'd6};
    pick(4'd4, 4'd5, 4'd6, 1'b0);

    // Reset while in COL.
    nib_q = '{4'd6};
    feed();
    check("row_before_reset", 32'(bus.pick_row), 32'd6);
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_pick",
          32'({bus.pick_valid, bus.gen_rand_flag, bus.pick_row, bus.pick_col,
               bus.pick_digit, bus.pick_folded}),
          32'({1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0}));
`ifdef PICKER_STATS_EN
    check("reset_mid_rej", 32'(rej_count), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    bus.en = 1'b1;
    nib_q = '{4'd2, 4'd3, 4'd4};
    pick(4'd2, 4'd3, 4'd4, 1'b0);

    // Drop en during OUT, then handshake: return to IDLE and ignore draws.
    bus.pick_ready = 1'b0;
    nib_q = '{4'd8, 4'd0, 4'd9};
    pick(4'd8, 4'd0, 4'd9, 1'b0);
    bus.en = 1'b0;
    tick();
    bus.pick_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.rand_vld = i[0];
      bus.rand_nib = 4'd3;
      tick();
      check("idle_ignore", 32'({bus.gen_rand_flag, bus.pick_valid}), 32'd0);
    end
    bus.rand_vld = 1'b0;
`ifdef PICKER_STATS_EN
    check("rej_after_idle", 32'(rej_count), 32'd0);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
